// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_ZERO = 2'd1,
    ST_ON       = 2'd2,
    ST_END      = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_seq_sub_step.sv
// One restoring-division trial subtraction: (WIDTH+1)-bit partial remainder
// minus the divisor, reporting the difference and whether no borrow occurred.
module div_sub_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);

  logic [WIDTH:0] d;
  logic           brw;

  assign {brw, d} = {1'b0, partial} - {2'b00, divisor};

  // The running remainder stays below the divisor, so a borrow-free difference
  // never needs bit WIDTH; folding it in keeps the kept difference WIDTH bits.
  assign no_borrow = ~brw & ~d[WIDTH];
  assign diff      = d[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider (DIV/DIVU), {remainder, quotient} result.
// Optional feature: define DIV_EARLY_OUT_EN to finish at once when |dividend| < |divisor|.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  div_state_e state, state_nxt;

  logic signed [WIDTH-1:0] dvd_s, dvs_s;
  logic                    dvd_neg, dvs_neg, dvs_zero, early_out, accept;
  logic [WIDTH-1:0]        dvd_mag, dvs_mag;

  logic [CW-1:0]           cnt_p0;
  logic [WIDTH-1:0]        rem_p0, dq_p0, dvs_p0;
  logic                    neg_q_p0, neg_r_p0;
  logic [WIDTH:0]          partial_p0;
  logic [WIDTH-1:0]        diff_p0;
  logic                    nb_p0;
  logic [WIDTH-1:0]        q_fix, r_fix;

  logic [2*WIDTH-1:0]      result_p1;
  logic                    vld_p1;

  assign dvd_s    = opdata1_i;
  assign dvs_s    = opdata2_i;
  assign dvd_neg  = signed_div_i && (dvd_s < 0);
  assign dvs_neg  = signed_div_i && (dvs_s < 0);
  assign dvd_mag  = dvd_neg ? f_neg(opdata1_i) : opdata1_i;
  assign dvs_mag  = dvs_neg ? f_neg(opdata2_i) : opdata2_i;
  assign dvs_zero = (opdata2_i == '0);
  assign accept   = (state == ST_IDLE) && start_i && !annul_i;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (dvd_mag < dvs_mag);
`else
  assign early_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (dvs_zero)       state_nxt = ST_DIV_ZERO;
          else if (early_out) state_nxt = ST_END;
          else                state_nxt = ST_ON;
        end
      end
      ST_DIV_ZERO: state_nxt = ST_END;
      ST_ON:       if (cnt_p0 == CW'(WIDTH - 1)) state_nxt = ST_END;
      ST_END:      state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (annul_i) state_nxt = ST_IDLE;
  end

  // ---- stage p0: operand capture and one restoring step per ON cycle ----
  assign partial_p0 = {rem_p0, dq_p0[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .partial   (partial_p0),
    .divisor   (dvs_p0),
    .diff      (diff_p0),
    .no_borrow (nb_p0)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_p0   <= '0;
      rem_p0   <= '0;
      dq_p0    <= '0;
      dvs_p0   <= '0;
      neg_q_p0 <= 1'b0;
      neg_r_p0 <= 1'b0;
    end else if (accept) begin
      cnt_p0 <= '0;
      dvs_p0 <= dvs_mag;
      // Zero divisor and early-out both present the raw dividend as remainder.
      if (dvs_zero || early_out) begin
        rem_p0   <= opdata1_i;
        dq_p0    <= dvs_zero ? '1 : '0;
        neg_q_p0 <= 1'b0;
        neg_r_p0 <= 1'b0;
      end else begin
        rem_p0   <= '0;
        dq_p0    <= dvd_mag;
        neg_q_p0 <= dvd_neg ^ dvs_neg;
        neg_r_p0 <= dvd_neg;
      end
    end else if (state == ST_ON) begin
      cnt_p0 <= cnt_p0 + CW'(1);
      rem_p0 <= nb_p0 ? diff_p0 : partial_p0[WIDTH-1:0];
      dq_p0  <= {dq_p0[WIDTH-2:0], nb_p0};
    end
  end

  assign q_fix = neg_q_p0 ? f_neg(dq_p0)  : dq_p0;
  assign r_fix = neg_r_p0 ? f_neg(rem_p0) : rem_p0;

  // ---- stage p1: registered result and ready pulse ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= (state == ST_END) && !annul_i;
      if ((state == ST_END) && !annul_i) result_p1 <= {r_fix, q_fix};
    end
  end

  assign result_o = result_p1;
  assign ready_o  = vld_p1;
  assign busy_o   = (state != ST_IDLE);

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq; expectations are hand-computed.
// Early-out latency expectations follow DIV_EARLY_OUT_EN.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i, signed_div_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, busy_o;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] last_res = '0;
  int          early_lat;

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive a start so that it is sampled at the next rising edge (edge T).
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    opdata1_i = a; opdata2_i = b; signed_div_i = sgn; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Called at T+1ns; counts edges to the ready pulse and checks the result.
  task automatic wait_ready(input string tag, input int lat, input logic [63:0] exp, input bit poke);
    int seen = -1;
    int k = 0;
    chk({tag, "_busy"}, 64'(busy_o), 64'd1);
    chk({tag, "_hold"}, result_o, last_res);
    while (seen < 0 && k < 60) begin
      k++;
      if (poke && k == 5) begin
        start_i = 1'b1; opdata1_i = 32'd1; opdata2_i = 32'd1;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      if (ready_o) seen = k;
    end
    chk({tag, "_lat"}, 64'(seen), 64'(lat));
    chk({tag, "_res"}, result_o, exp);
    last_res = exp;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
`ifdef DIV_EARLY_OUT_EN
    early_lat = 1;
`else
    early_lat = 33;
`endif
    resetn = 1'b0; start_i = 1'b0; signed_div_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result_o, 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Basic unsigned division, with a start pulse while busy that must be ignored.
    launch(32'd100, 32'd7, 1'b0);
    wait_ready("divu_100_7", 33, 64'h00000002_0000000E, 1'b1);

    launch(32'hFFFFFFF9, 32'd2, 1'b1);
    wait_ready("div_m7_2", 33, 64'hFFFFFFFF_FFFFFFFD, 1'b0);

    launch(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_ready("div_minneg", 33, 64'h00000000_80000000, 1'b0);

    launch(32'h12345678, 32'd0, 1'b0);
    wait_ready("divu_by0", 2, 64'h12345678_FFFFFFFF, 1'b0);

    launch(32'hFFFFFFF9, 32'd0, 1'b1);
    wait_ready("div_by0", 2, 64'hFFFFFFF9_FFFFFFFF, 1'b0);

    launch(32'd7, 32'hFFFFFFFE, 1'b1);
    wait_ready("div_7_m2", 33, 64'h00000001_FFFFFFFD, 1'b0);

    launch(32'hFFFFFFFF, 32'd16, 1'b0);
    wait_ready("divu_big", 33, 64'h0000000F_0FFFFFFF, 1'b0);

    launch(32'hFFFFFFFF, 32'd16, 1'b1);
    wait_ready("div_m1_16", early_lat, 64'hFFFFFFFF_00000000, 1'b0);

    launch(32'd3, 32'd10, 1'b0);
    wait_ready("divu_3_10", early_lat, 64'h00000003_00000000, 1'b0);

    // Annul during cycle T+10, then restart at T+12.
    begin
      bit any_rdy = 1'b0;
      launch(32'd100, 32'd7, 1'b0);
      for (int i = 1; i <= 10; i++) begin
        @(posedge clk); #1;
        if (ready_o) any_rdy = 1'b1;
      end
      annul_i = 1'b1;
      @(posedge clk); #1;
      annul_i = 1'b0;
      if (ready_o) any_rdy = 1'b1;
      chk("annul_busy", 64'(busy_o), 64'd0);
      chk("annul_noready", 64'(any_rdy), 64'd0);
      chk("annul_result", result_o, last_res);
      launch(32'd100, 32'd7, 1'b0);
      wait_ready("annul_restart", 33, 64'h00000002_0000000E, 1'b0);
    end

    // Start together with annul in IDLE must not begin an operation.
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    chk("idle_annul_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    chk("idle_annul_busy2", 64'(busy_o), 64'd0);

    // Annul while in END: no pulse, result unchanged.
    launch(32'h12345678, 32'd0, 1'b0);
    @(posedge clk); #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("end_annul_ready", 64'(ready_o), 64'd0);
    chk("end_annul_result", result_o, last_res);
    chk("end_annul_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    chk("end_annul_ready2", 64'(ready_o), 64'd0);

    // Asynchronous reset mid-division, then a cold-start division.
    launch(32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_result", result_o, 64'd0);
    chk("midrst_ready", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    last_res = '0;
    launch(32'd100, 32'd7, 1'b0);
    wait_ready("after_rst", 33, 64'h00000002_0000000E, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request to begin a division; sampled only in IDLE.
REQ-005 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-006 opdata1_i  input  WIDTH  dividend; sampled with start_i.
REQ-007 opdata2_i  input  WIDTH  divisor; sampled with start_i.
REQ-008 annul_i  input  1  abort the in-flight division (pipeline flush).
REQ-009 result_o  output  2*WIDTH  {remainder, quotient} = {HI, LO}.
REQ-010 ready_o  output  1  one-cycle pulse, result_o valid.
REQ-011 busy_o  output  1  high in every state except IDLE.

Function
REQ-012 The block SHALL implement states IDLE, DIV_ZERO, ON, END.
REQ-013 IDLE with start_i=1 and annul_i=0 SHALL latch operands and go to DIV_ZERO if opdata2_i==0, else ON.
REQ-014 ON SHALL perform one restoring step per cycle (WIDTH-bit shift, (WIDTH+1)-bit trial subtract, quotient bit = no-borrow) for exactly WIDTH cycles, then go to END.
REQ-015 Latency: start accepted at edge T SHALL give ready_o=1 in cycle T+WIDTH+1 (T+33 at default); divide-by-zero SHALL give ready_o in cycle T+2.
REQ-016 END SHALL assert ready_o for exactly one cycle and return to IDLE.
REQ-017 Signed mode SHALL divide magnitudes; quotient negated if operand signs differ, remainder takes dividend sign.
REQ-018 Signed most-negative / -1 SHALL yield quotient 0x80000000, remainder 0 (no trap).
REQ-019 Divide by zero SHALL yield quotient all ones, remainder = original dividend, in both modes.
REQ-020 result_o SHALL hold the last completed result until the next accepted start; it SHALL not change while busy.
REQ-021 start_i while busy_o=1 SHALL be ignored.
REQ-022 annul_i=1 in any non-IDLE state SHALL return to IDLE at the next edge with no ready_o pulse and result_o unchanged.
REQ-023 annul_i and start_i together in IDLE SHALL leave the block in IDLE.
REQ-024 annul_i in END SHALL suppress ready_o and SHALL keep result_o unchanged.

Reset
REQ-025 resetn low SHALL asynchronously force state IDLE, result_o=0, ready_o=0, busy_o=0, and clear all internal registers.
REQ-026 Reset mid-division SHALL discard the operation; the first start after release SHALL behave as from cold.

Configuration
REQ-027 Macro DIV_EARLY_OUT_EN defined: if |dividend| < |divisor| (nonzero divisor), IDLE SHALL go directly to END; ready_o at T+1, quotient 0, remainder = dividend.
REQ-028 Macro DIV_EARLY_OUT_EN undefined: every nonzero-divisor division SHALL take the full WIDTH+1-cycle latency.

Structure
REQ-029 A shared package SHALL hold the state enumeration and the WIDTH default constant.
REQ-030 The (WIDTH+1)-bit trial subtraction SHALL be a sub-module div_sub_step (inputs partial remainder and divisor; outputs difference and no-borrow bit), instantiated once.

Verification
REQ-031 DIVU 100 / 7 -> ready_o at T+33, result_o = {0x00000002, 0x0000000E}.
REQ-032 DIV -7 (0xFFFFFFF9) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000.
REQ-034 DIVU 0x12345678 / 0 -> ready_o at T+2, quotient 0xFFFFFFFF, remainder 0x12345678.
REQ-035 Start 100/7, annul_i at T+10 -> no ready_o, busy_o low at T+11, result_o unchanged; new start at T+12 completes normally.
REQ-036 DIVU 3 / 10 -> with DIV_EARLY_OUT_EN, ready_o at T+1; without it, ready_o at T+33; both give {0x00000003, 0x00000000}.
